// File: rtl/dwc_retry_ctrl.sv
// Duplication-with-comparison retry controller: two redundant registered AND
// copies, compared each pass, re-executed on mismatch up to MAX_RETRY times.
module dwc_retry_ctrl #(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             port_in_valid,
  output logic             port_in_ready,
  input  logic [WIDTH-1:0] port_in_a,
  input  logic [WIDTH-1:0] port_in_b,
  input  logic [WIDTH-1:0] port_inj_0,
  input  logic [WIDTH-1:0] port_inj_1,
  output logic             port_out_valid,
  input  logic             port_out_ready,
  output logic [WIDTH-1:0] port_out_data,
  output logic             port_out_fault,
  output logic             port_out_retried,
  output logic [CNT_W-1:0] port_err_count
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    CHECK   = 2'd2,
    OUT     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] reg0_q, reg1_q;
  logic [RW-1:0]    retry_q;
  logic             retried_q, fault_q;
  logic [CNT_W-1:0] err_q;

  logic accept, mismatch, retry_left;

  assign accept     = (state_q == IDLE) && port_in_valid;
  assign mismatch   = (reg0_q != reg1_q);
  assign retry_left = (retry_q < RW'(MAX_RETRY));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (port_in_valid) state_d = COMPUTE;
      COMPUTE: state_d = CHECK;
      CHECK: begin
        if (mismatch && retry_left) state_d = COMPUTE;
        else                        state_d = OUT;
      end
      OUT:     if (port_out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      reg0_q    <= '0;
      reg1_q    <= '0;
      retry_q   <= '0;
      retried_q <= 1'b0;
      fault_q   <= 1'b0;
      err_q     <= '0;
    end else begin
      if (accept) begin
        a_q       <= port_in_a;
        b_q       <= port_in_b;
        retry_q   <= '0;
        retried_q <= 1'b0;
        fault_q   <= 1'b0;
      end
      if (state_q == COMPUTE) begin
        reg0_q <= (a_q & b_q) ^ port_inj_0;
        reg1_q <= (a_q & b_q) ^ port_inj_1;
      end
      if (state_q == CHECK && mismatch) begin
        retried_q <= 1'b1;
        if (err_q != {CNT_W{1'b1}}) err_q <= err_q + 1'b1;
        // Retries exhausted: the result still leaves, but flagged.
        if (retry_left) retry_q <= retry_q + 1'b1;
        else            fault_q <= 1'b1;
      end
    end
  end

  // Ready is gated by rst_n so it reads 0 for the whole reset assertion.
  assign port_in_ready    = rst_n && (state_q == IDLE);
  assign port_out_valid   = (state_q == OUT);
  assign port_out_data    = reg0_q;
  assign port_out_fault   = fault_q;
  assign port_out_retried = retried_q;
  assign port_err_count   = err_q;

endmodule

// File: tb/tb_dwc_retry_ctrl.sv
// Directed bench for dwc_retry_ctrl; a second instance with CNT_W=2 shares the
// stimulus so counter saturation is observed alongside the main checks.
module tb_dwc_retry_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready;
  logic [7:0] in_a, in_b, inj_0, inj_1;

  logic       in_ready, out_valid, out_fault, out_retried;
  logic [7:0] out_data, err_count;
  logic       s_in_ready, s_out_valid, s_out_fault, s_out_retried;
  logic [7:0] s_out_data;
  logic [1:0] s_err_count;

  int passed = 0;
  int total  = 0;
  int n;
  logic [7:0] hold_data;

  always #5 clk = ~clk;

  dwc_retry_ctrl #(.WIDTH(8), .MAX_RETRY(2), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .port_in_valid(in_valid), .port_in_ready(in_ready),
    .port_in_a(in_a), .port_in_b(in_b),
    .port_inj_0(inj_0), .port_inj_1(inj_1),
    .port_out_valid(out_valid), .port_out_ready(out_ready),
    .port_out_data(out_data), .port_out_fault(out_fault),
    .port_out_retried(out_retried), .port_err_count(err_count)
  );

  dwc_retry_ctrl #(.WIDTH(8), .MAX_RETRY(2), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .port_in_valid(in_valid), .port_in_ready(s_in_ready),
    .port_in_a(in_a), .port_in_b(in_b),
    .port_inj_0(inj_0), .port_inj_1(inj_1),
    .port_out_valid(s_out_valid), .port_out_ready(out_ready),
    .port_out_data(s_out_data), .port_out_fault(s_out_fault),
    .port_out_retried(s_out_retried), .port_err_count(s_err_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Presents one operand pair, returns edges from the accepting edge (=1)
  // until out_valid is seen. A transient fault clears the masks after the
  // first COMPUTE has loaded the copies.
  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] i0, input logic [7:0] i1,
                       input bit transient, output int lat);
    @(negedge clk);
    in_a = a; in_b = b; inj_0 = i0; inj_1 = i1; in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 in_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (transient && lat == 2) begin
        inj_0 = 8'h00; inj_1 = 8'h00;
      end
    end
  endtask

  task automatic consume(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, out_valid, 1'b0);
    check({tag, "_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; inj_0 = '0; inj_1 = '0;

    // Reset values while rst_n is held low
    #12;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_flags", {out_fault, out_retried}, 2'b00);
    check("rst_err", err_count, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    #1 check("rel_in_ready", in_ready, 1'b1);
    check("rel_out_valid", out_valid, 1'b0);

    // Clean op
    issue(8'hF0, 8'h3C, 8'h00, 8'h00, 1'b0, n);
    check("clean_lat", n, 3);
    check("clean_data", out_data, 8'h30);
    check("clean_flags", {out_fault, out_retried}, 2'b00);
    check("clean_err", err_count, 8'd0);
    check("clean_in_ready", in_ready, 1'b0);
    consume("clean");

    // Transient fault on copy 0 in the first COMPUTE only
    issue(8'hF0, 8'h3C, 8'h01, 8'h00, 1'b1, n);
    check("trans_lat", n, 5);
    check("trans_data", out_data, 8'h30);
    check("trans_flags", {out_fault, out_retried}, 2'b01);
    check("trans_err", err_count, 8'd1);
    check("trans_sat_err", s_err_count, 2'd1);
    consume("trans");

    // Permanent fault on copy 1: retries exhausted
    issue(8'hF0, 8'h3C, 8'h00, 8'h80, 1'b0, n);
    check("perm_lat", n, 7);
    check("perm_data", out_data, 8'h30);
    check("perm_flags", {out_fault, out_retried}, 2'b11);
    check("perm_err", err_count, 8'd4);
    check("perm_sat_err", s_err_count, 2'd3);
    inj_1 = 8'h00;
    consume("perm");

    // Backpressure with ignored in_valid pulses
    out_ready = 1'b0;
    issue(8'hAA, 8'h0F, 8'h00, 8'h00, 1'b0, n);
    check("bp_lat", n, 3);
    hold_data = out_data;
    check("bp_data", hold_data, 8'h0A);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in_a = 8'hFF; in_b = 8'hFF;
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || out_data !== hold_data || in_ready !== 1'b0 ||
          out_fault !== 1'b0 || out_retried !== 1'b0) begin
        check("bp_stable", {out_valid, in_ready, out_fault, out_retried, out_data}, {4'b1000, hold_data});
      end
    end
    check("bp_stable_end", {out_valid, in_ready, out_data}, {2'b10, 8'h0A});
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    consume("bp");
    check("bp_err", err_count, 8'd4);

    // Reset during CHECK of a permanent-fault op
    @(negedge clk);
    in_a = 8'hF0; in_b = 8'h3C; inj_1 = 8'h80; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b0);
    check("mid_rst_outputs", {out_valid, out_fault, out_retried, out_data}, 11'd0);
    check("mid_rst_err", err_count, 8'd0);
    check("mid_rst_sat_err", s_err_count, 2'd0);
    @(negedge clk);
    inj_1 = 8'h00;
    rst_n = 1'b1;
    #1 check("mid_rel_state", {in_ready, out_valid}, 2'b10);
    issue(8'hFF, 8'h0F, 8'h00, 8'h00, 1'b0, n);
    check("post_rst_lat", n, 3);
    check("post_rst_data", out_data, 8'h0F);
    check("post_rst_flags", {out_fault, out_retried, err_count}, 10'd0);
    consume("post_rst");

    // Two permanent-fault ops: 6 mismatches, 2-bit counter sticks at 3
    issue(8'h55, 8'hFF, 8'h00, 8'h80, 1'b0, n);
    check("sat1_err", err_count, 8'd3);
    check("sat1_sat_err", s_err_count, 2'd3);
    consume("sat1");
    issue(8'h55, 8'hFF, 8'h00, 8'h80, 1'b0, n);
    check("sat2_lat", n, 7);
    check("sat2_data", s_out_data, 8'h55);
    check("sat2_err", err_count, 8'd6);
    check("sat2_sat_err", s_err_count, 2'd3);
    check("sat2_sat_flags", {s_out_fault, s_out_retried}, 2'b11);
    inj_1 = 8'h00;
    consume("sat2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
